load_store_unit: RTL and testbench

//  Memory-access stage directly downstream of the ALU: takes the ALU result as effective address plus rs2 as store data.

---
 rtl/rv32i_pkg.sv | 39 +++
 rtl/lsu_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I load/store definitions
// Purpose: FSM state encoding for the load/store unit, funct3 access codes,
//          and small decode helpers for op legality and alignment.
// Ports:   none (package).
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Neither or both of load/store, or a funct3 with no RV32I meaning.
  function automatic logic op_illegal(input logic ld, input logic st,
                                      input logic [2:0] f3);
    if (ld == st) return 1'b1;
    if (ld) return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return (f3 >= 3'b011);
  endfunction

  // Only meaningful for legal ops; f3[1:0] gives the size for both loads and stores.
  function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering and load extract/extend
// Purpose: combinational formatting between the 32-bit bus and the core.
// Ports:
//   funct3  in  3   access size/sign
//   lane    in  2   byte offset within the word
//   st_data in  32  store data from rs2
//   rdata   in  32  raw bus read data
//   wdata   out 32  lane-replicated store data
//   wstrb   out 4   byte strobes for the store size/lane
//   ld_val  out 32  extracted and extended load value
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // lane[0] is ignored for halfwords; misaligned halves are trapped upstream if enabled.
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = 32'h0;
    wstrb = 4'h0;
    case (funct3)
      F3_SB: begin
        wdata = {4{st_data[7:0]}};
        wstrb = 4'b0001 << lane;
      end
      F3_SH: begin
        wdata = {2{st_data[15:0]}};
        wstrb = lane[1] ? 4'b1100 : 4'b0011;
      end
      F3_SW: begin
        wdata = st_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_val = rdata;
    case (funct3)
      F3_LB:   ld_val = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ld_val = {24'h0, byte_sel};
      F3_LH:   ld_val = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ld_val = {16'h0, half_sel};
      F3_LW:   ld_val = rdata;
      default: ld_val = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-transaction RV32I load/store unit
// Purpose: runs one load or store on a ready-handshake bus and returns the
//          formatted load value. IDLE -> REQ -> DONE -> IDLE.
// Config:  LSU_MISALIGN_TRAP_EN - trap misaligned half/word accesses
//          (misalign=1, no bus access); undefined, misalign is always 0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 1-cycle request, taken only in IDLE
//   is_load, is_store     op kind
//   funct3, addr, st_data access size/sign, effective address, rs2
//   mem_req/we/addr/wdata/wstrb  registered bus request
//   mem_rdata, mem_ready  bus response
//   busy, done            in-flight flag, 1-cycle completion pulse
//   ld_data, err, misalign  results, valid with done
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        err,
  output logic        misalign
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  lsu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic          load_q;

  logic          illegal;
  logic          trap_mis;
  logic          timeout;
  logic [2:0]    al_f3;
  logic [1:0]    al_lane;
  logic [31:0]   al_wdata;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_ld_val;

  assign illegal = op_illegal(is_load, is_store, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_mis = op_misaligned(funct3, addr[1:0]);
`else
  assign trap_mis = 1'b0;
`endif

  assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // One formatter is shared: in IDLE it steers the incoming store, in REQ it
  // extracts the load using the access shape captured at start.
  assign al_f3   = (state_q == ST_IDLE) ? funct3 : f3_q;
  assign al_lane = (state_q == ST_IDLE) ? addr[1:0] : lane_q;

  lsu_align u_align (
    .funct3  (al_f3),
    .lane    (al_lane),
    .st_data (st_data),
    .rdata   (mem_rdata),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb),
    .ld_val  (al_ld_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (illegal || trap_mis) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        // Ready and timeout together: ready wins, which the DONE transition covers.
        if (mem_ready || timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are flops decoded from the next state so they line up
  // with the state register and clear the instant reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      mem_req <= (state_d == ST_REQ);
      busy    <= (state_d == ST_REQ);
      done    <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      load_q    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      ld_data   <= 32'h0;
      err       <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            ld_data  <= 32'h0;
            err      <= illegal;
            misalign <= !illegal && trap_mis;
            if (!illegal && !trap_mis) begin
              f3_q      <= funct3;
              lane_q    <= addr[1:0];
              load_q    <= is_load;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= is_store ? al_wdata : 32'h0;
              mem_wstrb <= is_store ? al_wstrb : 4'h0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            if (load_q) ld_data <= al_ld_val;
          end else if (timeout) begin
            err     <= 1'b1;
            ld_data <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;
  import rv32i_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] ld_data;
  logic        err;
  logic        misalign;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .st_data   (st_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .ld_data   (ld_data),
    .err       (err),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    is_load = ld; is_store = st; funct3 = f3; addr = a; st_data = sd;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".ld_data"}, ld_data, e.ld);
      check({tag, ".err"}, {31'h0, err}, {31'h0, e.err});
      check({tag, ".misalign"}, {31'h0, misalign}, {31'h0, e.mis});
    end
  endtask

  // delay >= TO means mem_ready is never given.
  task automatic do_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int delay, input logic bus, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                       input logic [31:0] e_ld, input logic e_err, input logic e_mis);
    exp_t e;
    int   n;
    int   lat;
    e.ld = e_ld; e.err = e_err; e.mis = e_mis;
    sb.push_back(e);
    lat = !bus ? 0 : ((delay >= TO) ? TO : delay + 1);
    issue(ld, st, f3, a, sd);
    if (bus) begin
      check({tag, ".req"}, {31'h0, mem_req}, 32'd1);
      check({tag, ".busy"}, {31'h0, busy}, 32'd1);
      check({tag, ".addr"}, mem_addr, e_addr);
      check({tag, ".we"}, {31'h0, mem_we}, {31'h0, st});
      check({tag, ".wstrb"}, {28'h0, mem_wstrb}, {28'h0, e_wstrb});
      if (st) check({tag, ".wdata"}, mem_wdata, e_wdata);
    end else begin
      check({tag, ".no_req"}, {31'h0, mem_req}, 32'd0);
    end
    n = 0;
    while (!done && n < TO + 4) begin
      mem_ready = (delay < TO) && (n == delay);
      mem_rdata = rd;
      step();
      mem_ready = 1'b0;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".done"}, {31'h0, done}, 32'd1);
    check({tag, ".busy_done"}, {31'h0, busy}, 32'd0);
    check({tag, ".req_done"}, {31'h0, mem_req}, 32'd0);
    check_result(tag);
    step();
    check({tag, ".done_pulse"}, {31'h0, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    step();
    check("rst.req", {31'h0, mem_req}, 32'd0);
    check("rst.we", {31'h0, mem_we}, 32'd0);
    check("rst.busy", {31'h0, busy}, 32'd0);
    check("rst.done", {31'h0, done}, 32'd0);
    check("rst.err", {31'h0, err}, 32'd0);
    check("rst.mis", {31'h0, misalign}, 32'd0);
    check("rst.addr", mem_addr, 32'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    check("rst.wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst.ld", ld_data, 32'h0);
    rst_n = 1'b1;
    step();

    do_op("lb",  1, 0, F3_LB,  32'h103, 32'h0, 32'h80FF_FF7F, 0, 1, 32'h100, 32'h0, 4'h0, 32'hFFFF_FF80, 0, 0);
    do_op("lbu", 1, 0, F3_LBU, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 1, 32'h100, 32'h0, 4'h0, 32'h0000_0080, 0, 0);
    do_op("sh",  0, 1, F3_SH,  32'h202, 32'h1234_ABCD, 32'h0, 2, 1, 32'h200, 32'hABCD_ABCD, 4'b1100, 32'h0, 0, 0);
    do_op("sb",  0, 1, F3_SB,  32'h001, 32'hAABB_CC5A, 32'h0, 0, 1, 32'h000, 32'h5A5A_5A5A, 4'b0010, 32'h0, 0, 0);
    do_op("lh",  1, 0, F3_LH,  32'h012, 32'h0, 32'h8001_7FFF, 0, 1, 32'h010, 32'h0, 4'h0, 32'hFFFF_8001, 0, 0);
    do_op("lhu", 1, 0, F3_LHU, 32'h010, 32'h0, 32'h8001_7FFF, 3, 1, 32'h010, 32'h0, 4'h0, 32'h0000_7FFF, 0, 0);
    do_op("lw_timeout", 1, 0, F3_LW, 32'h080, 32'h0, 32'h5555_5555, TO, 1, 32'h080, 32'h0, 4'h0, 32'h0, 1, 0);
    do_op("lw_last",    1, 0, F3_LW, 32'h084, 32'h0, 32'hDEAD_BEEF, TO - 1, 1, 32'h084, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_op("lw_mis", 1, 0, F3_LW, 32'h006, 32'h0, 32'h1122_3344, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 1);
`else
    do_op("lw_mis", 1, 0, F3_LW, 32'h006, 32'h0, 32'h1122_3344, 0, 1, 32'h004, 32'h0, 4'h0, 32'h1122_3344, 0, 0);
`endif
    do_op("ill_both", 1, 1, F3_LW,  32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 0);
    do_op("ill_ldf3", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 0);
    do_op("ill_stf3", 0, 1, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 0);

    // A second start while REQ is in flight must not disturb or queue.
    e.ld = 32'h0F0F_0F0F; e.err = 1'b0; e.mis = 1'b0;
    sb.push_back(e);
    issue(1, 0, F3_LW, 32'h040, 32'h0);
    check("ign.req", {31'h0, mem_req}, 32'd1);
    issue(0, 1, F3_SW, 32'h999, 32'hFFFF_FFFF);
    check("ign.addr", mem_addr, 32'h040);
    check("ign.we", {31'h0, mem_we}, 32'd0);
    check("ign.busy", {31'h0, busy}, 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0F0F_0F0F;
    step();
    mem_ready = 1'b0;
    check("ign.done", {31'h0, done}, 32'd1);
    check_result("ign");
    step();
    step();
    check("ign.idle_req", {31'h0, mem_req}, 32'd0);
    check("ign.idle_busy", {31'h0, busy}, 32'd0);
    check("ign.idle_done", {31'h0, done}, 32'd0);

    // Reset in the middle of a request, then a late ready.
    issue(0, 1, F3_SW, 32'h300, 32'h0000_0001);
    check("rmid.req", {31'h0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid.req_drop", {31'h0, mem_req}, 32'd0);
    check("rmid.busy_drop", {31'h0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("rmid.late_done", {31'h0, done}, 32'd0);
    check("rmid.late_req", {31'h0, mem_req}, 32'd0);
    do_op("sw", 0, 1, F3_SW, 32'h300, 32'hCAFE_F00D, 32'h0, 1, 1, 32'h300, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 0);

    check("sb.drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
